hr_meas_ctrl: RTL and testbench

HR_MEAS_CTRL -- requirements
Module: hr_meas_ctrl

---
 rtl/hr_pkg.sv | 15 +
 rtl/hr_beat_det.sv | 46 ++++
 rtl/hr_meas_ctrl.sv | 108 ++++++++++
 tb/tb_hr_meas_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hr_pkg.sv
// Shared definitions for the heart-rate measurement controller: FSM states and
// default parameter values.
package hr_pkg;

    localparam int REFRACT_CYC_DEF = 25_000_000;
    localparam int CNT_W_DEF       = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_COUNT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/hr_beat_det.sv
// Beat detector: 2-FF synchronizer, rising-edge detector and refractory timer.
// A beat strobe is issued only while armed and the refractory timer is idle.
module hr_beat_det
    import hr_pkg::*;
#(
    parameter int REFRACT_CYC = REFRACT_CYC_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic pulse_in,
    input  logic arm,
    output logic beat
);

    localparam int RW = (REFRACT_CYC > 1) ? $clog2(REFRACT_CYC) : 1;
    localparam logic [RW-1:0] RELOAD = RW'(REFRACT_CYC - 1);

    logic          sync_a;
    logic          sync_b;
    logic          sync_d;
    logic [RW-1:0] refr;
    logic          rise;

    assign rise = sync_b & ~sync_d;
    // Edges seen while the timer runs are dropped without reloading it.
    assign beat = rise & arm & (refr == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            sync_d <= 1'b0;
            refr   <= '0;
        end else begin
            sync_a <= pulse_in;
            sync_b <= sync_a;
            sync_d <= sync_b;
            if (beat) begin
                refr <= RELOAD;
            end else if (refr != '0) begin
                refr <= refr - 1'b1;
            end
        end
    end

endmodule

// File: rtl/hr_meas_ctrl.sv
// Heart-rate measurement controller: counts beats over a 60 s window supplied
// by an external window counter and reports the count directly as bpm.
module hr_meas_ctrl
    import hr_pkg::*;
#(
    parameter int REFRACT_CYC = REFRACT_CYC_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             pulse_in,
    input  logic             win_done,
    output logic             en_cont,
    output logic             busy,
    output logic [CNT_W-1:0] bpm,
    output logic             bpm_valid,
    output logic             ovf,
    output logic             no_sig
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state;
    logic [CNT_W-1:0] count;
    logic             sat;
    logic             beat;
    logic [CNT_W-1:0] cnt_inc;
    logic             sat_inc;

    hr_beat_det #(
        .REFRACT_CYC(REFRACT_CYC)
    ) u_beat_det (
        .clk     (clk),
        .rst     (rst),
        .pulse_in(pulse_in),
        .arm     (state == ST_COUNT),
        .beat    (beat)
    );

    // Count including this cycle's beat, so a beat coinciding with win_done lands in bpm.
    always_comb begin
        cnt_inc = count;
        sat_inc = sat;
        if (beat) begin
            if (count == CNT_MAX) begin
                sat_inc = 1'b1;
            end else begin
                cnt_inc = count + 1'b1;
            end
        end
    end

    assign en_cont = (state == ST_COUNT);
    assign busy    = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            count     <= '0;
            sat       <= 1'b0;
            bpm       <= '0;
            bpm_valid <= 1'b0;
            ovf       <= 1'b0;
            no_sig    <= 1'b0;
        end else begin
            bpm_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start && !abort) begin
                        state <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    count <= '0;
                    sat   <= 1'b0;
                    // Hold the window counter disabled until its stale done level drops.
                    if (abort) begin
                        state <= ST_IDLE;
                    end else if (!win_done) begin
                        state <= ST_COUNT;
                    end
                end
                ST_COUNT: begin
                    count <= cnt_inc;
                    sat   <= sat_inc;
                    if (abort) begin
                        state <= ST_IDLE;
                    end else if (win_done) begin
                        state     <= ST_DONE;
                        bpm       <= cnt_inc;
                        ovf       <= sat_inc;
                        no_sig    <= (cnt_inc == '0);
                        bpm_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hr_meas_ctrl.sv
// Randomized self-checking bench for hr_meas_ctrl with a beat-count reference
// model derived from pulse spacing and the refractory rule.
module tb_hr_meas_ctrl;

    localparam int REFRACT = 4;
    localparam int CW      = 8;
    localparam int MAXV    = (1 << CW) - 1;

    logic          clk;
    logic          rst;
    logic          start;
    logic          abort;
    logic          pulse_in;
    logic          win_done;
    logic          en_cont;
    logic          busy;
    logic [CW-1:0] bpm;
    logic          bpm_valid;
    logic          ovf;
    logic          no_sig;

    int total;
    int bad;
    int nstrobe;
    int plan[$];
    int e_bpm;
    int e_ovf;
    int e_nosig;

    hr_meas_ctrl #(
        .REFRACT_CYC(REFRACT),
        .CNT_W      (CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .pulse_in (pulse_in),
        .win_done (win_done),
        .en_cont  (en_cont),
        .busy     (busy),
        .bpm      (bpm),
        .bpm_valid(bpm_valid),
        .ovf      (ovf),
        .no_sig   (no_sig)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bpm_valid === 1'b1) nstrobe++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic fill_rand(input int n, input int gmin, input int gmax);
        plan.delete();
        for (int i = 0; i < n; i++) plan.push_back($urandom_range(gmax, gmin));
    endtask

    // Runs one full measurement using the gaps in plan (cycles between rising edges).
    task automatic do_meas(input bit edge_at_end, input string tag);
        int t, last, n, s0;
        bit en_lost;
        s0 = nstrobe; t = 0; last = -1000; n = 0; en_lost = 1'b0;
        start = 1'b1; tick(1); start = 1'b0;
        check({tag, "_clr_en"}, en_cont, 0);
        check({tag, "_clr_busy"}, busy, 1);
        tick(1);
        check({tag, "_lat_en"}, en_cont, 1);
        tick(2);
        foreach (plan[i]) begin
            if (t - last >= REFRACT) begin
                n++;
                last = t;
            end
            pulse_in = 1'b1; tick(1);
            pulse_in = 1'b0;
            if (plan[i] > 1) tick(plan[i] - 1);
            if (en_cont !== 1'b1) en_lost = 1'b1;
            t += plan[i];
        end
        if (edge_at_end) begin
            tick(5);
            n++;
            pulse_in = 1'b1; tick(1);
            pulse_in = 1'b0; tick(1);
        end else begin
            tick(5);
        end
        win_done = 1'b1; tick(1);
        e_bpm   = (n > MAXV) ? MAXV : n;
        e_ovf   = (n > MAXV) ? 1 : 0;
        e_nosig = (n == 0) ? 1 : 0;
        check({tag, "_en_held"}, en_lost, 0);
        check({tag, "_valid"}, bpm_valid, 1);
        check({tag, "_bpm"}, bpm, e_bpm);
        check({tag, "_ovf"}, ovf, e_ovf);
        check({tag, "_nosig"}, no_sig, e_nosig);
        check({tag, "_en_done"}, en_cont, 0);
        tick(1);
        check({tag, "_valid_off"}, bpm_valid, 0);
        check({tag, "_idle"}, busy, 0);
        check({tag, "_strobes"}, nstrobe - s0, 1);
        win_done = 1'b0;
        tick(1);
    endtask

    initial begin
        int s0;
        total = 0; bad = 0; nstrobe = 0;
        rst = 1'b0; start = 1'b0; abort = 1'b0; pulse_in = 1'b0; win_done = 1'b0;
        tick(3);
        check("rst_bpm", bpm, 0);
        check("rst_valid", bpm_valid, 0);
        check("rst_ovf", ovf, 0);
        check("rst_nosig", no_sig, 0);
        check("rst_en", en_cont, 0);
        check("rst_busy", busy, 0);
        rst = 1'b1;
        tick(2);

        plan.delete();
        for (int i = 0; i < 10; i++) plan.push_back(10);
        do_meas(1'b0, "norm");
        check("norm_fixed", bpm, 10);

        plan.delete();
        plan.push_back(2); plan.push_back(6); plan.push_back(6);
        do_meas(1'b0, "refr");
        check("refr_fixed", bpm, 2);

        plan.delete();
        do_meas(1'b0, "zero");
        check("zero_nosig", no_sig, 1);

        for (int k = 0; k < 6; k++) begin
            fill_rand($urandom_range(40, 0), 2, 7);
            do_meas(1'b0, $sformatf("rnd%0d", k));
        end

        fill_rand(5, 2, 7);
        do_meas(1'b1, "edge_end");

        plan.delete();
        for (int i = 0; i < 300; i++) plan.push_back(5);
        do_meas(1'b0, "sat");
        check("sat_fixed", bpm, 255);

        // Stale window at start
        s0 = nstrobe;
        win_done = 1'b1; start = 1'b1; tick(1); start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("stale_en%0d", i), en_cont, 0);
            tick(1);
        end
        win_done = 1'b0;
        check("stale_en4", en_cont, 0);
        check("stale_busy", busy, 1);
        tick(1);
        check("stale_count", en_cont, 1);
        tick(2);
        pulse_in = 1'b1; tick(1); pulse_in = 1'b0; tick(6);
        win_done = 1'b1; tick(1);
        check("stale_valid", bpm_valid, 1);
        check("stale_bpm", bpm, 1);
        check("stale_ovf", ovf, 0);
        tick(1);
        win_done = 1'b0;
        check("stale_strobes", nstrobe - s0, 1);
        e_bpm = 1; e_ovf = 0; e_nosig = 0;
        tick(1);

        // Abort after 3 beats, with an ignored start while busy
        s0 = nstrobe;
        start = 1'b1; tick(1); start = 1'b0; tick(2);
        for (int i = 0; i < 3; i++) begin
            pulse_in = 1'b1; tick(1); pulse_in = 1'b0; tick(5);
        end
        start = 1'b1; tick(1); start = 1'b0;
        check("busy_start_ign", en_cont, 1);
        abort = 1'b1; tick(1); abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_en", en_cont, 0);
        check("abort_bpm", bpm, e_bpm);
        check("abort_ovf", ovf, e_ovf);
        check("abort_nosig", no_sig, e_nosig);
        tick(2);
        check("abort_strobes", nstrobe - s0, 0);

        start = 1'b1; abort = 1'b1; tick(1); start = 1'b0; abort = 1'b0;
        check("start_abort", busy, 0);

        win_done = 1'b1; start = 1'b1; tick(1); start = 1'b0;
        check("clr_busy", busy, 1);
        abort = 1'b1; tick(1); abort = 1'b0; win_done = 1'b0;
        check("clr_abort", busy, 0);
        tick(1);

        // Reset in the middle of COUNT
        s0 = nstrobe;
        start = 1'b1; tick(1); start = 1'b0; tick(2);
        pulse_in = 1'b1; tick(1); pulse_in = 1'b0; tick(5);
        win_done = 1'b1;
        #2 rst = 1'b0;
        #1;
        check("mrst_en", en_cont, 0);
        check("mrst_busy", busy, 0);
        check("mrst_bpm", bpm, 0);
        check("mrst_valid", bpm_valid, 0);
        check("mrst_ovf", ovf, 0);
        check("mrst_nosig", no_sig, 0);
        tick(2);
        win_done = 1'b0;
        rst = 1'b1;
        tick(2);
        check("mrst_strobes", nstrobe - s0, 0);

        fill_rand(12, 2, 7);
        do_meas(1'b0, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
